// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words and tags each with a program address.
// Optional field checking is compiled in with INSTR_ENC_CHECK_EN.
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic              in_imm_sel,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [17:0]       in_imm,
  input  logic [26:0]       in_offset,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wrap
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]        r_state;
  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last;
  logic              r_done;
  logic              r_wrap;

  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_is_branch;
  logic        w_is_zero;
  logic        w_drop;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [31:0] w_enc;

  assign in_ready   = (r_state == ACTIVE) && (!r_out_valid || out_ready);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  assign w_is_branch = (in_op[4:2] == 3'b100);
  assign w_is_zero   = (in_op == 5'b10100) || (in_op == 5'b01101);
  // cmp has no destination; not/mov have no first source
  assign w_rd  = (in_op == 5'b00101) ? 4'd0 : in_rd;
  assign w_rs1 = ((in_op == 5'b01000) || (in_op == 5'b01001)) ? 4'd0 : in_rs1;

  always_comb begin
    w_enc = '0;
    if (w_is_branch)     w_enc = {in_op, in_offset};
    else if (w_is_zero)  w_enc = {in_op, 27'd0};
    else if (in_imm_sel) w_enc = {in_op, 1'b1, w_rd, w_rs1, in_imm};
    else                 w_enc = {in_op, 1'b0, w_rd, w_rs1, in_rs2, 14'd0};
  end

`ifdef INSTR_ENC_CHECK_EN
  logic r_err;

  assign w_drop = (in_op > 5'b10100) || (in_imm_sel && (w_is_branch || w_is_zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_err <= 1'b0;
    else if ((r_state == IDLE) && start) r_err <= 1'b0;
    else if (w_in_xfer && w_drop)        r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_drop = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= '0;
      r_addr      <= '0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_done <= w_out_xfer && r_last;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ACTIVE;
            r_addr  <= ADDR_W'(BASE_ADDR);
            r_wrap  <= 1'b0;
          end
        end
        ACTIVE:  if (w_in_xfer && in_last) r_state <= DRAIN;
        DRAIN:   if (!r_out_valid || w_out_xfer) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // a new load and a drain in the same cycle keep out_valid high
      if (w_in_xfer && !w_drop) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_enc;
        r_out_addr  <= r_addr;
        r_last      <= in_last;
        r_addr      <= r_addr + ADDR_W'(1);
        if (r_addr == {ADDR_W{1'b1}}) r_wrap <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
        r_last      <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign busy      = (r_state == ACTIVE) || (r_state == DRAIN);
  assign done      = r_done;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with a queue-based scoreboard on the output port.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic        in_imm_sel = 1'b0;
  logic [3:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [17:0] in_imm = '0;
  logic [26:0] in_offset = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [1:0]  out_addr;
  logic        busy, done, err, wrap;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [1:0]  exp_addr = '0;
  logic [33:0] exp_q[$];

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm_sel(in_imm_sel),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_offset(in_offset), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .busy(busy), .done(done), .err(err), .wrap(wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output word must match the head of the queue.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h@%0d required=none", out_instr, out_addr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", out_instr, e[33:2]);
        chk("sb_addr", 32'(out_addr), 32'(e[1:0]));
      end
    end
  end

  // All tasks are entered and left one time unit after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic send(input logic [4:0] op, input logic isel, input logic [3:0] rd,
                      input logic [3:0] rs1, input logic [3:0] rs2, input logic [17:0] imm,
                      input logic [26:0] off, input logic last, input logic [31:0] exp,
                      input logic drop);
    int n = 0;
    in_op = op; in_imm_sel = isel; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_offset = off; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_handshake_timeout actual=in_ready0 required=in_ready1");
    end else if (!drop) begin
      exp_q.push_back({exp, exp_addr});
      exp_addr = exp_addr + 2'd1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    logic seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_pulse", 32'(seen), 32'd1);
    if (seen) begin
      chk("busy_with_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    logic any;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // add, mov, beq(last)
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    send(5'b00000, 1'b0, 4'd3, 4'd1, 4'd2, 18'h0, 27'h0, 1'b0, 32'h00C48000, 1'b0);
    send(5'b01001, 1'b1, 4'd5, 4'd7, 4'd0, 18'h0002A, 27'h0, 1'b0, 32'h4D40002A, 1'b0);
    send(5'b10000, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0000010, 1'b1, 32'h80000010, 1'b0);
    wait_done();

    // five back-to-back words on a 2-bit address: 0,1,2,3,0 and wrap after the fourth
    pulse_start();
    c0 = cyc;
    send(5'b00101, 1'b1, 4'd7, 4'd2, 4'd0, 18'h3FFFF, 27'h0, 1'b0, 32'h2C0BFFFF, 1'b0);
    send(5'b10100, 1'b0, 4'd9, 4'd9, 4'd9, 18'h1, 27'h5555555, 1'b0, 32'hA0000000, 1'b0);
    send(5'b10011, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h7FFFFFF, 1'b0, 32'h9FFFFFFF, 1'b0);
    chk("wrap_before_4th", 32'(wrap), 32'd0);
    send(5'b01000, 1'b0, 4'd1, 4'd15, 4'd9, 18'h0, 27'h0, 1'b0, 32'h40424000, 1'b0);
    chk("wrap_after_4th", 32'(wrap), 32'd1);
    send(5'b01101, 1'b0, 4'd3, 4'd3, 4'd3, 18'h3, 27'h3, 1'b1, 32'h68000000, 1'b0);
    chk("stream_cycles", 32'(cyc - c0), 32'd5);
    wait_done();
    chk("wrap_sticky", 32'(wrap), 32'd1);

    // backpressure, start ignored while active, in_ready low in DRAIN
    pulse_start();
    chk("start_clears_wrap", 32'(wrap), 32'd0);
    out_ready = 1'b0;
    send(5'b00000, 1'b0, 4'd3, 4'd1, 4'd2, 18'h0, 27'h0, 1'b0, 32'h00C48000, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      send(5'b01001, 1'b1, 4'd5, 4'd0, 4'd0, 18'h0002A, 27'h0, 1'b0, 32'h4D40002A, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_instr", out_instr, 32'h00C48000);
          chk("stall_addr", 32'(out_addr), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    send(5'b10000, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0000010, 1'b1, 32'h80000010, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done();

`ifdef INSTR_ENC_CHECK_EN
    pulse_start();
    send(5'b11000, 1'b0, 4'd1, 4'd1, 4'd1, 18'h0, 27'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("chk_err_set", 32'(err), 32'd1);
    chk("chk_no_output", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(5'b00000, 1'b0, 4'd3, 4'd1, 4'd2, 18'h0, 27'h0, 1'b0, 32'h00C48000, 1'b0);
    send(5'b10000, 1'b1, 4'd0, 4'd0, 4'd0, 18'h0, 27'h10, 1'b1, 32'h0, 1'b1);
    any = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy) begin
        any = 1'b1;
        break;
      end
    end
    chk("chk_drop_last_idle", 32'(any), 32'd1);
    chk("chk_err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1;
    pulse_start();
    chk("start_clears_err", 32'(err), 32'd0);
    send(5'b01101, 1'b0, 4'd0, 4'd0, 4'd0, 18'h0, 27'h0, 1'b1, 32'h68000000, 1'b0);
    wait_done();
`else
    pulse_start();
    send(5'b11000, 1'b0, 4'd1, 4'd1, 4'd1, 18'h0, 27'h0, 1'b1, 32'hC0444000, 1'b0);
    chk("nochk_err_zero", 32'(err), 32'd0);
    wait_done();
`endif

    // reset in the middle of a load discards the pending word
    pulse_start();
    out_ready = 1'b0;
    send(5'b00000, 1'b0, 4'd3, 4'd1, 4'd2, 18'h0, 27'h0, 1'b1, 32'h00C48000, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_instr", out_instr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any = any | done | out_valid;
    end
    chk("midrst_no_done", 32'(any), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
